ct_ifu_icache_predecd_bank: RTL

- Parametrised single-port predecode storage bank for the IFU icache; next generation of the per-way predecode array.
- Generalised in depth, data width and bit-write granularity, and adds behaviour the fixed-size array lacks:
  - automatic clear sweep after reset;
  - one-entry posted write buffer with read forwarding;
  - selectable read latency.
- Sits between the icache refill/fetch control and a behavioural (or macro-substituted) storage array. One instance per way.

---
 rtl/ct_ifu_predecd_pkg.sv | 31 +++
 rtl/ct_ifu_predecd_sram.sv | 38 +++
 rtl/ct_ifu_icache_predecd_bank.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ct_ifu_predecd_pkg.sv
// Shared types and helpers for the IFU icache predecode storage bank.
// Word and index fields are sized to the largest supported configuration;
// each bank zero-extends into them and truncates back to its own widths.
package ct_ifu_predecd_pkg;

    localparam int PD_MAX_DATA_W = 256;
    localparam int PD_MAX_IDX_W  = 20;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } pd_state_t;

    typedef logic [PD_MAX_DATA_W-1:0] pd_word_t;

    // mask is held bit-expanded so the merge is a plain bitwise select
    typedef struct packed {
        logic                    vld;
        logic [PD_MAX_IDX_W-1:0] idx;
        pd_word_t                data;
        pd_word_t                mask;
    } pd_wbuf_t;

    // Masked bits come from the buffered word, the rest from the array word.
    function automatic pd_word_t pd_merge(input pd_word_t arr_word,
                                          input pd_word_t wb_word,
                                          input pd_word_t bit_mask);
        return (arr_word & ~bit_mask) | (wb_word & bit_mask);
    endfunction

endpackage

// File: rtl/ct_ifu_predecd_sram.sv
// Single-port predecode array: per-segment write enable, synchronous read,
// contents not reset. Replace with a memory macro of the same interface.
module ct_ifu_predecd_sram
    import ct_ifu_predecd_pkg::*;
#(
    parameter int  DEPTH  = 1024,
    parameter int  DATA_W = 32,
    parameter int  SEG_W  = 8,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int NSEG   = DATA_W / SEG_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              wen,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] din,
    input  logic [NSEG-1:0]   bwen,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // One access per enabled cycle: masked segment write, or read into dout.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) begin
                for (int s = 0; s < NSEG; s++) begin
                    if (bwen[s]) begin
                        mem[idx][s*SEG_W +: SEG_W] <= din[s*SEG_W +: SEG_W];
                    end
                end
            end else begin
                dout <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/ct_ifu_icache_predecd_bank.sv
// Predecode storage bank for one icache way: post-reset clear sweep,
// one-entry posted write buffer with read forwarding, 1- or 2-cycle reads.
module ct_ifu_icache_predecd_bank
    import ct_ifu_predecd_pkg::*;
#(
    parameter int  DEPTH  = 1024,
    parameter int  DATA_W = 32,
    parameter int  SEG_W  = 8,
    parameter int  RD_LAT = 1,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int NSEG   = DATA_W / SEG_W
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              cp0_yy_clk_en,
    input  logic              req_vld,
    input  logic              req_wen,
    input  logic [IDX_W-1:0]  req_idx,
    input  logic [DATA_W-1:0] req_din,
    input  logic [NSEG-1:0]   req_bwen,
    output logic              req_rdy,
    input  logic              init_req,
    output logic              init_busy,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_dout
);

    if (DATA_W > PD_MAX_DATA_W || IDX_W > PD_MAX_IDX_W || (DATA_W % SEG_W) != 0 ||
        DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || (RD_LAT != 1 && RD_LAT != 2)) begin : g_param_err
        $error("ct_ifu_icache_predecd_bank: unsupported parameter set");
    end

    pd_state_t         state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    pd_wbuf_t          wbuf_q, wbuf_d;
    pd_word_t          req_bm;
    logic              sweep, acc_rd, acc_wr, drain, fwd_hit;

    logic              sram_en, sram_wen;
    logic [IDX_W-1:0]  sram_idx;
    logic [DATA_W-1:0] sram_din, sram_dout;
    logic [NSEG-1:0]   sram_bwen;

    logic              rd_vld1_q;
    pd_word_t          fwd_data_q, fwd_mask_q;
    logic [DATA_W-1:0] merged, dout_q;

    assign sweep     = (state_q == INIT);
    assign init_busy = sweep;
    assign req_rdy   = (state_q == IDLE) & ~init_req;
    assign acc_rd    = req_vld & req_rdy & ~req_wen;
    assign acc_wr    = req_vld & req_rdy & req_wen & (|req_bwen);
    // a write cycle never reads, so the old entry can always drain alongside it
    assign drain     = (state_q == IDLE) & ~init_req & ~acc_rd & wbuf_q.vld;
    assign fwd_hit   = wbuf_q.vld & (wbuf_q.idx == PD_MAX_IDX_W'(req_idx));

    // Expand the segment write mask to a bit mask for storage and merging.
    always_comb begin
        req_bm = '0;
        for (int s = 0; s < NSEG; s++) begin
            req_bm[s*SEG_W +: SEG_W] = {SEG_W{req_bwen[s]}};
        end
    end

    // Next state, sweep counter and write buffer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wbuf_d  = wbuf_q;
        case (state_q)
            INIT: begin
                if (init_req) begin
                    cnt_d = '0;
                end else if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            IDLE: begin
                if (init_req) begin
                    state_d    = INIT;
                    cnt_d      = '0;
                    wbuf_d.vld = 1'b0;
                end else if (acc_wr) begin
                    wbuf_d.vld  = 1'b1;
                    wbuf_d.idx  = PD_MAX_IDX_W'(req_idx);
                    wbuf_d.data = pd_word_t'(req_din);
                    wbuf_d.mask = req_bm;
                end else if (drain) begin
                    wbuf_d.vld = 1'b0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Array port arbitration: sweep, then accepted read, then buffer drain.
    always_comb begin
        sram_wen  = 1'b0;
        sram_idx  = req_idx;
        sram_din  = '0;
        sram_bwen = '0;
        if (sweep) begin
            sram_wen  = 1'b1;
            sram_idx  = cnt_q;
            sram_bwen = '1;
        end else if (acc_rd) begin
            sram_idx = req_idx;
        end else if (drain) begin
            sram_wen = 1'b1;
            sram_idx = IDX_W'(wbuf_q.idx);
            sram_din = DATA_W'(wbuf_q.data);
            for (int s = 0; s < NSEG; s++) begin
                sram_bwen[s] = wbuf_q.mask[s*SEG_W];
            end
        end
    end

    assign sram_en = cp0_yy_clk_en & (sweep | acc_rd | drain);

    // Control state registers.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            wbuf_q  <= '0;
        end else if (cp0_yy_clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wbuf_q  <= wbuf_d;
        end
    end

    // Read pipeline: snapshot the buffer at acceptance so forwarding sees
    // the entry as it was when the read was taken.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rd_vld1_q  <= 1'b0;
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
            dout_q     <= '0;
        end else if (cp0_yy_clk_en) begin
            rd_vld1_q <= acc_rd;
            if (acc_rd) begin
                fwd_data_q <= wbuf_q.data;
                fwd_mask_q <= fwd_hit ? wbuf_q.mask : '0;
            end
            if (rd_vld1_q) begin
                dout_q <= merged;
            end
        end
    end

    assign merged = DATA_W'(pd_merge(pd_word_t'(sram_dout), fwd_data_q, fwd_mask_q));

    if (RD_LAT == 2) begin : g_lat2
        logic vld2_q;

        // Extra output stage; dout_q already captures the merged word.
        always_ff @(posedge forever_cpuclk or posedge cpurst) begin
            if (cpurst) begin
                vld2_q <= 1'b0;
            end else if (cp0_yy_clk_en) begin
                vld2_q <= rd_vld1_q;
            end
        end

        assign rd_vld  = vld2_q;
        assign rd_dout = dout_q;
    end else begin : g_lat1
        assign rd_vld  = rd_vld1_q;
        assign rd_dout = rd_vld1_q ? merged : dout_q;
    end

    ct_ifu_predecd_sram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .SEG_W  (SEG_W)
    ) u_sram (
        .clk  (forever_cpuclk),
        .en   (sram_en),
        .wen  (sram_wen),
        .idx  (sram_idx),
        .din  (sram_din),
        .bwen (sram_bwen),
        .dout (sram_dout)
    );

endmodule
